any1_agen_pipe: RTL and testbench

- Parametrised, handshaked address-generation stage sitting between the ANY-1 register-read stage and the load/store unit.
- Computes effective address from base, scaled index and immediate, with offset / pre-increment / post-increment addressing.
- Produces byte-lane selects for a BUS_BYTES-wide data bus.
- Splits bus-crossing misaligned accesses into two beats, or flags them when SPLIT_EN=0.

---
 rtl/any1_pkg.sv | 35 +++
 rtl/any1_agen_calc.sv | 66 ++++++
 rtl/any1_agen_pipe.sv | 167 ++++++++++++++++
 tb/tb_any1_agen_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/any1_pkg.sv
// Shared types and helpers for the ANY-1 address-generation stage.
// Holds access/mode encodings, FSM states and the byte-lane mask helper.
package any1_pkg;

  typedef enum logic [1:0] {
    AGEN_LD  = 2'd0,
    AGEN_LDX = 2'd1,
    AGEN_ST  = 2'd2,
    AGEN_STX = 2'd3
  } agen_op_t;

  typedef enum logic [1:0] {
    AGEN_OFS  = 2'd0,
    AGEN_PRE  = 2'd1,
    AGEN_POST = 2'd2,
    AGEN_RSVD = 2'd3
  } agen_mode_t;

  typedef enum logic [1:0] {
    AGEN_IDLE  = 2'd0,
    AGEN_ONE   = 2'd1,
    AGEN_SPLIT = 2'd2
  } agen_state_t;

  // Wide enough for two beats of the largest supported bus (2 x 16 lanes).
  localparam int SEL_MASK_W = 32;

  function automatic logic [SEL_MASK_W-1:0] sel_mask(input logic [3:0] lo,
                                                     input logic [1:0] size);
    logic [SEL_MASK_W-1:0] m;
    m = (SEL_MASK_W'(1) << (5'd1 << size)) - SEL_MASK_W'(1);
    return m << lo;
  endfunction

endpackage

// File: rtl/any1_agen_calc.sv
// Combinational effective-address, writeback-value and lane-mask calculation
// for one load/store request.
module any1_agen_calc
  import any1_pkg::*;
#(
  parameter int AWID      = 32,
  parameter int BUS_BYTES = 8
) (
  input  logic [1:0]             i_op,
  input  logic [1:0]             i_mode,
  input  logic [1:0]             i_scale,
  input  logic [1:0]             i_size,
  input  logic [AWID-1:0]        i_base,
  input  logic [AWID-1:0]        i_index,
  input  logic [AWID-1:0]        i_imm,
  output logic [AWID-1:0]        o_ea,
  output logic [AWID-1:0]        o_wb_val,
  output logic                   o_wb_en,
  output logic [2*BUS_BYTES-1:0] o_full,
  output logic                   o_cross
);

  localparam int LOW = $clog2(BUS_BYTES);

  agen_op_t              w_op;
  agen_mode_t            w_mode;
  logic [AWID-1:0]       w_idx;
  logic [AWID-1:0]       w_sum;
  logic [AWID-1:0]       w_ea;
  logic [3:0]            w_lo;
  logic [SEL_MASK_W-1:0] w_mask;

  assign w_op   = agen_op_t'(i_op);
  assign w_mode = agen_mode_t'(i_mode);

  assign w_idx = ((w_op == AGEN_LDX) || (w_op == AGEN_STX)) ? (i_index << i_scale) : '0;
  assign w_sum = i_base + i_imm + w_idx;

  // The reserved mode encoding behaves exactly like plain offset addressing.
  always_comb begin
    w_ea     = w_sum;
    o_wb_val = w_sum;
    o_wb_en  = 1'b0;
    unique case (w_mode)
      AGEN_PRE: begin
        o_wb_en = 1'b1;
      end
      AGEN_POST: begin
        w_ea    = i_base;
        o_wb_en = 1'b1;
      end
      default: begin
        o_wb_en = 1'b0;
      end
    endcase
  end

  assign o_ea   = w_ea;
  assign w_lo   = 4'(w_ea[LOW-1:0]);
  assign w_mask = sel_mask(w_lo, i_size);
  assign o_full = w_mask[2*BUS_BYTES-1:0];

  // Any lane beyond the first bus word means the access spills into the next one.
  assign o_cross = |w_mask[SEL_MASK_W-1:BUS_BYTES];

endmodule

// File: rtl/any1_agen_pipe.sv
// Handshaked address-generation stage: registers one request, presents it as
// one or two bus beats and pulses the base-register writeback.
module any1_agen_pipe
  import any1_pkg::*;
#(
  parameter int AWID      = 32,
  parameter int BUS_BYTES = 8,
  parameter int TAGW      = 4,
  parameter int SPLIT_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [1:0]           in_mode,
  input  logic [1:0]           in_scale,
  input  logic [1:0]           in_size,
  input  logic [AWID-1:0]      in_base,
  input  logic [AWID-1:0]      in_index,
  input  logic [AWID-1:0]      in_imm,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AWID-1:0]      out_ea,
  output logic [BUS_BYTES-1:0] out_sel,
  output logic                 out_st,
  output logic                 out_last,
  output logic                 out_misalign,
  output logic [TAGW-1:0]      out_tag,
  output logic                 wb_valid,
  output logic [AWID-1:0]      wb_val
);

  localparam logic [AWID-1:0] ALIGN_MASK = ~AWID'(BUS_BYTES - 1);
  localparam logic [AWID-1:0] BUS_STEP   = AWID'(BUS_BYTES);
  localparam bit              DO_SPLIT   = (SPLIT_EN != 0);

  agen_state_t r_state;
  agen_state_t w_next;

  logic [AWID-1:0]      r_ea;
  logic [BUS_BYTES-1:0] r_sel;
  logic                 r_st;
  logic                 r_last;
  logic                 r_misalign;
  logic [TAGW-1:0]      r_tag;
  logic [AWID-1:0]      r_wb_val;
  logic                 r_wb_en;
  logic                 r_split_pend;
  logic [AWID-1:0]      r_nxt_ea;
  logic [BUS_BYTES-1:0] r_hi_sel;

  logic [AWID-1:0]        w_ea;
  logic [AWID-1:0]        w_wb_val;
  logic                   w_wb_en;
  logic [2*BUS_BYTES-1:0] w_full;
  logic                   w_cross;
  logic                   w_split;
  logic                   w_misalign;
  logic                   w_accept;
  logic                   w_is_st;
  logic                   w_beat2;

  any1_agen_calc #(
    .AWID      (AWID),
    .BUS_BYTES (BUS_BYTES)
  ) u_calc (
    .i_op     (in_op),
    .i_mode   (in_mode),
    .i_scale  (in_scale),
    .i_size   (in_size),
    .i_base   (in_base),
    .i_index  (in_index),
    .i_imm    (in_imm),
    .o_ea     (w_ea),
    .o_wb_val (w_wb_val),
    .o_wb_en  (w_wb_en),
    .o_full   (w_full),
    .o_cross  (w_cross)
  );

  assign w_split    = w_cross && DO_SPLIT;
  assign w_misalign = w_cross && !DO_SPLIT;
  assign w_is_st    = (agen_op_t'(in_op) == AGEN_ST) || (agen_op_t'(in_op) == AGEN_STX);

  // A new request may enter as the final beat of the previous access retires.
  assign out_valid = (r_state != AGEN_IDLE);
  assign in_ready  = rst_n && (!out_valid || (out_ready && r_last));
  assign w_accept  = in_valid && in_ready;
  assign w_beat2   = (r_state == AGEN_ONE) && out_ready && r_split_pend;
  assign wb_valid  = (r_state == AGEN_ONE) && out_ready && r_wb_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AGEN_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      AGEN_IDLE: begin
        if (w_accept) w_next = AGEN_ONE;
      end
      AGEN_ONE: begin
        if (out_ready) begin
          if (r_split_pend) w_next = AGEN_SPLIT;
          else if (w_accept) w_next = AGEN_ONE;
          else w_next = AGEN_IDLE;
        end
      end
      AGEN_SPLIT: begin
        if (out_ready) w_next = w_accept ? AGEN_ONE : AGEN_IDLE;
      end
      default: begin
        w_next = AGEN_IDLE;
      end
    endcase
  end

  // Output register: loads a new request, or swaps in the pending second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ea         <= '0;
      r_sel        <= '0;
      r_st         <= 1'b0;
      r_last       <= 1'b0;
      r_misalign   <= 1'b0;
      r_tag        <= '0;
      r_wb_val     <= '0;
      r_wb_en      <= 1'b0;
      r_split_pend <= 1'b0;
      r_nxt_ea     <= '0;
      r_hi_sel     <= '0;
    end else if (w_accept) begin
      r_ea         <= w_ea;
      r_sel        <= w_full[BUS_BYTES-1:0];
      r_st         <= w_is_st;
      r_last       <= !w_split;
      r_misalign   <= w_misalign;
      r_tag        <= in_tag;
      r_wb_val     <= w_wb_val;
      r_wb_en      <= w_wb_en && !w_misalign;
      r_split_pend <= w_split;
      r_nxt_ea     <= (w_ea & ALIGN_MASK) + BUS_STEP;
      r_hi_sel     <= w_full[2*BUS_BYTES-1:BUS_BYTES];
    end else if (w_beat2) begin
      r_ea         <= r_nxt_ea;
      r_sel        <= r_hi_sel;
      r_last       <= 1'b1;
      r_wb_en      <= 1'b0;
      r_split_pend <= 1'b0;
    end
  end

  assign out_ea       = r_ea;
  assign out_sel      = r_sel;
  assign out_st       = r_st;
  assign out_last     = r_last;
  assign out_misalign = r_misalign;
  assign out_tag      = r_tag;
  assign wb_val       = r_wb_val;

endmodule

// File: tb/tb_any1_agen_pipe.sv
// Scoreboard bench for any1_agen_pipe: one split-enabled instance plus a
// split-disabled instance for the misalign flag.
module tb_any1_agen_pipe;

  localparam int AW = 32;
  localparam int BB = 8;
  localparam int TW = 4;

  typedef struct {
    logic [AW-1:0] ea;
    logic [BB-1:0] sel;
    logic          st;
    logic          last;
    logic          mis;
    logic [TW-1:0] tag;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    in_op, in_mode, in_scale, in_size;
  logic [AW-1:0] in_base, in_index, in_imm;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_ea;
  logic [BB-1:0] out_sel;
  logic          out_st, out_last, out_misalign;
  logic [TW-1:0] out_tag;
  logic          wb_valid;
  logic [AW-1:0] wb_val;

  logic          ns_in_valid, ns_in_ready;
  logic          ns_out_valid, ns_out_ready;
  logic [AW-1:0] ns_out_ea;
  logic [BB-1:0] ns_out_sel;
  logic          ns_out_st, ns_out_last, ns_out_misalign;
  logic [TW-1:0] ns_out_tag;
  logic          ns_wb_valid;
  logic [AW-1:0] ns_wb_val;

  int checks   = 0;
  int failures = 0;

  beat_t         expQ[$];
  logic [AW-1:0] wbQ[$];

  always #5 clk = ~clk;

  any1_agen_pipe #(.AWID(AW), .BUS_BYTES(BB), .TAGW(TW), .SPLIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_mode(in_mode), .in_scale(in_scale), .in_size(in_size),
    .in_base(in_base), .in_index(in_index), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ea(out_ea), .out_sel(out_sel), .out_st(out_st), .out_last(out_last),
    .out_misalign(out_misalign), .out_tag(out_tag),
    .wb_valid(wb_valid), .wb_val(wb_val)
  );

  any1_agen_pipe #(.AWID(AW), .BUS_BYTES(BB), .TAGW(TW), .SPLIT_EN(0)) u_ns (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_op(in_op), .in_mode(in_mode), .in_scale(in_scale), .in_size(in_size),
    .in_base(in_base), .in_index(in_index), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready),
    .out_ea(ns_out_ea), .out_sel(ns_out_sel), .out_st(ns_out_st), .out_last(ns_out_last),
    .out_misalign(ns_out_misalign), .out_tag(ns_out_tag),
    .wb_valid(ns_wb_valid), .wb_val(ns_wb_val)
  );

  // Pops the scoreboard whenever the split-enabled instance retires a beat or a writeback.
  task automatic run_monitor();
    beat_t         e;
    logic [AW-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL beat_unexpected got ea=%h sel=%h required no beat", out_ea, out_sel);
        end else begin
          e = expQ.pop_front();
          if (out_ea !== e.ea || out_sel !== e.sel || out_st !== e.st || out_last !== e.last ||
              out_misalign !== e.mis || out_tag !== e.tag) begin
            failures++;
            $display("[TB] FAIL beat got ea=%h sel=%h st=%b last=%b mis=%b tag=%h required ea=%h sel=%h st=%b last=%b mis=%b tag=%h",
                     out_ea, out_sel, out_st, out_last, out_misalign, out_tag,
                     e.ea, e.sel, e.st, e.last, e.mis, e.tag);
          end
        end
      end
      if (rst_n && wb_valid) begin
        checks++;
        if (wbQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL wb_unexpected got wb_val=%h required no pulse", wb_val);
        end else begin
          w = wbQ.pop_front();
          if (wb_val !== w) begin
            failures++;
            $display("[TB] FAIL wb_val got %h required %h", wb_val, w);
          end
        end
      end
    end
  endtask

  // Drives one request until accepted, pushing the beats and writeback it must produce.
  task automatic send(input logic [1:0] op, input logic [1:0] mode, input logic [1:0] scale,
                      input logic [1:0] size, input logic [AW-1:0] base, input logic [AW-1:0] index,
                      input logic [AW-1:0] imm, input logic [TW-1:0] tag);
    logic [AW-1:0] idx, sum, ea;
    logic [15:0]   full;
    logic          st;
    bit            acc;
    int            cnt;
    beat_t         b;
    idx  = (op == 2'd1 || op == 2'd3) ? (index << scale) : '0;
    sum  = base + imm + idx;
    ea   = (mode == 2'd2) ? base : sum;
    full = ((16'd1 << (5'd1 << size)) - 16'd1) << ea[2:0];
    st   = (op == 2'd2 || op == 2'd3);
    in_op = op; in_mode = mode; in_scale = scale; in_size = size;
    in_base = base; in_index = index; in_imm = imm; in_tag = tag;
    in_valid = 1'b1;
    acc = 0;
    cnt = 0;
    while (!acc && cnt < 20) begin
      @(negedge clk); #1;
      if (in_ready) begin
        acc = 1;
        if (full[15:8] != 8'h00) begin
          b = '{ea, full[7:0], st, 1'b0, 1'b0, tag};
          expQ.push_back(b);
          b = '{(ea & ~32'h7) + 32'd8, full[15:8], st, 1'b1, 1'b0, tag};
          expQ.push_back(b);
        end else begin
          b = '{ea, full[7:0], st, 1'b1, 1'b0, tag};
          expQ.push_back(b);
        end
        if (mode == 2'd1 || mode == 2'd2) wbQ.push_back(sum);
      end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("[TB] FAIL accept_timeout got in_ready=0 for 20 cycles required acceptance");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; ns_in_valid = 1'b0;
    out_ready = 1'b0; ns_out_ready = 1'b1;
    in_op = '0; in_mode = '0; in_scale = '0; in_size = '0;
    in_base = '0; in_index = '0; in_imm = '0; in_tag = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got valid=%b wb=%b ready=%b required 0 0 0", out_valid, wb_valid, in_ready);
    end
    checks++;
    if (out_ea !== '0 || out_sel !== '0 || out_tag !== '0 || wb_val !== '0 ||
        out_st !== 1'b0 || out_last !== 1'b0 || out_misalign !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_data got ea=%h sel=%h tag=%h wb=%h st=%b last=%b mis=%b required all 0",
               out_ea, out_sel, out_tag, wb_val, out_st, out_last, out_misalign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready got %b required 1", in_ready);
    end
    idle(1);
  endtask

  task automatic test_offset();
    out_ready = 1'b1;
    send(2'd0, 2'd0, 2'd0, 2'd3, 32'h1000, 32'h0, 32'h10, 4'h1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_ea !== 32'h1010 || out_sel !== 8'hFF || wb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL offset_latency got valid=%b ea=%h sel=%h wb=%b required 1 00001010 ff 0",
               out_valid, out_ea, out_sel, wb_valid);
    end
    idle(2);
  endtask

  task automatic test_indexed();
    out_ready = 1'b1;
    send(2'd1, 2'd0, 2'd3, 2'd2, 32'h2000, 32'd5, 32'd4, 4'h2);
    @(negedge clk);
    checks++;
    if (out_ea !== 32'h202C || out_sel !== 8'hF0 || out_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL indexed got ea=%h sel=%h last=%b required 0000202c f0 1", out_ea, out_sel, out_last);
    end
    idle(2);
  endtask

  task automatic test_split();
    out_ready = 1'b1;
    send(2'd2, 2'd0, 2'd0, 2'd3, 32'h1000, 32'h0, 32'h4, 4'h3);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_last !== 1'b0 || out_sel !== 8'hF0 || out_st !== 1'b1) begin
      failures++;
      $display("[TB] FAIL split_beat1 got ready=%b last=%b sel=%h st=%b required 0 0 f0 1",
               in_ready, out_last, out_sel, out_st);
    end
    @(negedge clk);
    checks++;
    if (out_ea !== 32'h1008 || out_sel !== 8'h0F || out_last !== 1'b1 || out_st !== 1'b1) begin
      failures++;
      $display("[TB] FAIL split_beat2 got ea=%h sel=%h last=%b st=%b required 00001008 0f 1 1",
               out_ea, out_sel, out_last, out_st);
    end
    idle(2);
  endtask

  task automatic test_post_pre();
    out_ready = 1'b1;
    send(2'd0, 2'd2, 2'd0, 2'd3, 32'h3000, 32'h0, 32'h8, 4'h4);
    @(negedge clk);
    checks++;
    if (out_ea !== 32'h3000 || wb_valid !== 1'b1 || wb_val !== 32'h3008) begin
      failures++;
      $display("[TB] FAIL post got ea=%h wb=%b wb_val=%h required 00003000 1 00003008", out_ea, wb_valid, wb_val);
    end
    idle(1);
    send(2'd0, 2'd1, 2'd0, 2'd2, 32'hFFFF_FFFC, 32'h0, 32'h8, 4'h5);
    @(negedge clk);
    checks++;
    if (out_ea !== 32'h4 || wb_val !== 32'h4 || out_sel !== 8'hF0) begin
      failures++;
      $display("[TB] FAIL pre_wrap got ea=%h wb_val=%h sel=%h required 00000004 00000004 f0", out_ea, wb_val, out_sel);
    end
    idle(2);
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send(2'd3, 2'd2, 2'd0, 2'd3, 32'h1004, 32'h0, 32'h10, 4'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_ea !== 32'h1004 || out_sel !== 8'hF0 || out_tag !== 4'h6 ||
          wb_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_%0d got valid=%b ea=%h sel=%h tag=%h wb=%b ready=%b required 1 00001004 f0 6 0 0",
                 i, out_valid, out_ea, out_sel, out_tag, wb_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_beat2 got wb=%b last=%b ready=%b required 0 1 1", wb_valid, out_last, in_ready);
    end
    idle(2);
  endtask

  task automatic test_nosplit();
    in_op = 2'd2; in_mode = 2'd2; in_scale = 2'd0; in_size = 2'd3;
    in_base = 32'h1004; in_index = '0; in_imm = 32'h10; in_tag = 4'h7;
    ns_in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ns_in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nosplit_ready got %b required 1", ns_in_ready);
    end
    @(posedge clk); #1;
    ns_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ns_out_valid !== 1'b1 || ns_out_ea !== 32'h1004 || ns_out_sel !== 8'hF0 || ns_out_last !== 1'b1 ||
        ns_out_misalign !== 1'b1 || ns_out_st !== 1'b1 || ns_wb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nosplit got valid=%b ea=%h sel=%h last=%b mis=%b st=%b wb=%b required 1 00001004 f0 1 1 1 0",
               ns_out_valid, ns_out_ea, ns_out_sel, ns_out_last, ns_out_misalign, ns_out_st, ns_wb_valid);
    end
    @(negedge clk);
    checks++;
    if (ns_out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nosplit_single got valid=%b required 0", ns_out_valid);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    time t0;
    out_ready = 1'b1;
    t0 = $time;
    send(2'd0, 2'd0, 2'd0, 2'd0, 32'h100, 32'h0, 32'h1, 4'h8);
    send(2'd2, 2'd0, 2'd0, 2'd1, 32'h200, 32'h0, 32'h2, 4'h9);
    send(2'd1, 2'd1, 2'd2, 2'd2, 32'h300, 32'h2, 32'h0, 4'hA);
    send(2'd3, 2'd0, 2'd1, 2'd3, 32'h400, 32'h4, 32'h0, 4'hB);
    checks++;
    if (($time - t0) != 40) begin
      failures++;
      $display("[TB] FAIL back_to_back got %0t time units required 40", $time - t0);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_split();
    out_ready = 1'b1;
    send(2'd2, 2'd0, 2'd0, 2'd3, 32'h5000, 32'h0, 32'h6, 4'hC);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    expQ.delete();
    wbQ.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_split got valid=%b ready=%b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_ready got %b required 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stray_beat_%0d got valid=%b ea=%h required valid 0", i, out_valid, out_ea);
      end
    end
    idle(1);
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_offset();
    test_indexed();
    test_split();
    test_post_pre();
    test_hold();
    test_nosplit();
    test_back_to_back();
    test_reset_mid_split();
    checks++;
    if (expQ.size() != 0 || wbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got beats=%0d wb=%0d required 0 0", expQ.size(), wbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
